seq_logic_pipe: RTL and testbench

SEQ_LOGIC_PIPE -- requirements
Module: seq_logic_pipe

---
 rtl/seq_logic_pkg.sv | 12 +
 rtl/seq_stage.sv | 21 ++
 rtl/seq_logic_pipe.sv | 90 +++++++++
 tb/tb_seq_logic_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seq_logic_pkg.sv
// Shared types for the seq_logic_pipe delay-line block.
// The operating-mode encoding is the only thing shared between the block and its users.
package seq_logic_pkg;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      LOAD  = 2'd1,
      DELAY = 2'd2,
      EDGE  = 2'd3
   } mode_t;

endpackage

// File: rtl/seq_stage.sv
// One W-bit delay-line register with synchronous active-high reset and clock enable.
module seq_stage #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Reset wins over enable so a reset edge always empties the stage
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/seq_logic_pipe.sv
// Delay line with a mode-selected registered output: hold, load, delayed copy, or rising-edge detect.
// A fill counter tracks how much of the delay line holds post-reset data so valid is never early.
module seq_logic_pipe
   import seq_logic_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [W-1:0] A,
   input  logic [1:0]   mode,
   input  logic         en,
   output logic [W-1:0] F,
   output logic         valid
);

   localparam int             CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

   logic [W-1:0]  stage [DEPTH];
   logic [CW-1:0] cnt;
   mode_t         cur_mode;
   logic [W-1:0]  f_next;
   logic          valid_next;

   assign cur_mode = mode_t'(mode);

   // The line shifts on every enabled edge regardless of mode, so switching modes never flushes it
   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_stage
         logic [W-1:0] d;
         if (g == 0) begin : g_head
            assign d = A;
         end else begin : g_tail
            assign d = stage[g-1];
         end
         seq_stage #(.W(W)) u_stage (
            .clk (CLK),
            .rst (RST),
            .en  (en),
            .d   (d),
            .q   (stage[g])
         );
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Decisions use the pre-edge counter and stage values, matching what is being shifted out
   always_comb begin
      f_next     = F;
      valid_next = valid;
      case (cur_mode)
         LOAD: begin
            f_next     = A;
            valid_next = 1'b1;
         end
         DELAY: begin
            f_next     = stage[DEPTH-1];
            valid_next = (cnt == CNT_MAX);
         end
         EDGE: begin
            f_next     = A & ~stage[0];
            valid_next = (cnt != '0);
         end
         default: begin
            f_next     = F;
            valid_next = valid;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         F     <= '0;
         valid <= 1'b0;
      end else if (en) begin
         F     <= f_next;
         valid <= valid_next;
      end
   end

endmodule

// File: tb/tb_seq_logic_pipe.sv
// Self-checking bench for seq_logic_pipe (W=4, DEPTH=3): directed scenarios pinned by literal
// expectations, then random traffic compared every cycle against a queue-based history model.
module tb_seq_logic_pipe;
   import seq_logic_pkg::*;

   localparam int W     = 4;
   localparam int DEPTH = 3;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] A;
   logic [1:0]   mode;
   logic         en;
   logic [W-1:0] F;
   logic         valid;

   int checks = 0;
   int errors = 0;

   // Model: history of sampled A values (index 0 = most recent), edges since reset, expected outputs
   logic [W-1:0] hist [$];
   int           fill;
   logic [W-1:0] exp_f;
   logic         exp_valid;
   bit           model_ok = 1'b0;

   seq_logic_pipe #(.W(W), .DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .A     (A),
      .mode  (mode),
      .en    (en),
      .F     (F),
      .valid (valid)
   );

   always #5 CLK = ~CLK;

   task automatic modelEdge(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] a);
      if (r) begin
         exp_f     = '0;
         exp_valid = 1'b0;
         hist.delete();
         for (int i = 0; i < DEPTH; i++) hist.push_back('0);
         fill      = 0;
         model_ok  = 1'b1;
      end else if (e) begin
         case (m)
            2'd1: begin exp_f = a;                exp_valid = 1'b1;            end
            2'd2: begin exp_f = hist[DEPTH-1];    exp_valid = (fill >= DEPTH); end
            2'd3: begin exp_f = a & ~hist[0];     exp_valid = (fill >= 1);     end
            default: ;
         endcase
         hist.push_front(a);
         void'(hist.pop_back());
         if (fill < DEPTH) fill++;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] a);
      RST  = r;
      en   = e;
      mode = m;
      A    = a;
      @(posedge CLK);
      modelEdge(r, e, m, a);
      @(negedge CLK);
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] ef, input logic ev);
      checks++;
      if (F !== ef || valid !== ev) begin
         errors++;
         $display("[TB] FAIL %s: got F=%h valid=%b, expected F=%h valid=%b", name, F, valid, ef, ev);
      end
   endtask

   // Every-cycle comparison against the history model once it has seen a reset
   always @(negedge CLK) begin
      if (model_ok) begin
         checks++;
         if (F !== exp_f || valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL model @%0t: got F=%h valid=%b, expected F=%h valid=%b",
                     $time, F, valid, exp_f, exp_valid);
         end
      end
   end

   initial begin
      logic [W-1:0] dly_f [5];
      logic         dly_v [5];
      dly_f = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2};
      dly_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      RST = 1'b1; en = 1'b1; mode = LOAD; A = 4'hF;
      @(negedge CLK);

      // Reset overrides LOAD, then LOAD takes effect after release
      applyStimulus(1'b1, 1'b1, LOAD, 4'hF);
      checkOutput("reset_edge1", 4'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, LOAD, 4'hF);
      checkOutput("reset_edge2", 4'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, LOAD, 4'hF);
      checkOutput("load_after_reset", 4'hF, 1'b1);

      // DELAY latency of DEPTH+1 edges
      applyStimulus(1'b1, 1'b1, DELAY, 4'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, DELAY, W'(i + 1));
         checkOutput($sformatf("delay_edge%0d", i + 1), dly_f[i], dly_v[i]);
      end

      // EDGE detect: 0, 6, 3 -> 0, 6, 1
      applyStimulus(1'b1, 1'b1, EDGE, 4'h0);
      applyStimulus(1'b0, 1'b1, EDGE, 4'h0);
      checkOutput("edge_1", 4'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, EDGE, 4'h6);
      checkOutput("edge_2", 4'h6, 1'b1);
      applyStimulus(1'b0, 1'b1, EDGE, 4'h3);
      checkOutput("edge_3", 4'h1, 1'b1);

      // Disabled edges freeze everything, whatever the mode and data
      applyStimulus(1'b0, 1'b0, LOAD,  4'hA);
      checkOutput("en0_1", 4'h1, 1'b1);
      applyStimulus(1'b0, 1'b0, EDGE,  4'h5);
      checkOutput("en0_2", 4'h1, 1'b1);
      applyStimulus(1'b0, 1'b0, DELAY, 4'hA);
      checkOutput("en0_3", 4'h1, 1'b1);

      // HOLD keeps F but the line keeps shifting, so DELAY then shows the first held sample
      applyStimulus(1'b0, 1'b1, HOLD, 4'h7);
      checkOutput("hold_7", 4'h1, 1'b1);
      applyStimulus(1'b0, 1'b1, HOLD, 4'h8);
      checkOutput("hold_8", 4'h1, 1'b1);
      applyStimulus(1'b0, 1'b1, HOLD, 4'h9);
      checkOutput("hold_9", 4'h1, 1'b1);
      applyStimulus(1'b0, 1'b1, DELAY, 4'hA);
      checkOutput("hold_then_delay", 4'h7, 1'b1);

      // Mid-run reset discards the full pipeline and valid waits DEPTH edges again
      applyStimulus(1'b0, 1'b1, DELAY, 4'hB);
      applyStimulus(1'b1, 1'b1, DELAY, 4'hC);
      checkOutput("midrun_reset", 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, DELAY, W'(i + 1));
         checkOutput($sformatf("midrun_wait%0d", i + 1), 4'h0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, DELAY, 4'h4);
      checkOutput("midrun_recover", 4'h1, 1'b1);

      // Random traffic checked by the model process
      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                       2'($urandom_range(0, 3)), W'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
